mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Round-robin controller sharing one shift-add multiplier between two requesters.
- Per granted request: drives the multiplier's operand-load and readback protocol (func/oe/data), pulses start, waits on ready, reads the 2n-bit product and returns it with a one-cycle done pulse.
- Sits between the requester logic and the multiplier core; the top level owns the tristate data pad.

Parameters:
- n, 8, operand width; product width is 2n.
- START_HOLD, 4, cycles start is held high; must cover the start debounce window.
- TIMEOUT, 1024, maximum cycles in WAIT_BUSY plus WAIT_DONE before abort.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  2  request per requester; level, held until done
- a  in  2 x n  operand A per requester (packed [1:0][n-1:0])
- b  in  2 x n  operand B per requester
- done  out  2  one-cycle completion pulse per requester
- error  out  1  one-cycle pulse with done when the operation timed out
- product  out  2n  result of the last completed operation
- busy  out  1  high in any state other than IDLE
- start  out  1  multiplier start request
- func  out  2  multiplier function: 00 load M, 01 load Q, 10 read low, 11 read high
- oe  out  1  multiplier output enable
- data_o  out  n  operand driven toward the multiplier
- data_drive  out  1  top level drives data_o onto the pad when high
- data_i  in  n  pad value read back from the multiplier
- ready  in  1  multiplier ready; low while a multiplication runs

Behaviour:
- Reset values: done=0, error=0, product=0, busy=0, start=0, func=2'b10, oe=0, data_drive=0, data_o=0. Round-robin pointer favours requester 0. FSM goes to IDLE.
- Idle bus state is func=10 with oe=0, so no register write and no pad drive.
- Arbitration in IDLE:
  - Exactly one req high: that requester is granted.
  - Both high: grant the requester that was not granted last.
  - The grant latches the pointer and captures a[g] and b[g] into internal registers. Later operand changes are ignored.
- FSM, one state per cycle unless noted:
  - IDLE: on a grant go to LOAD_M.
  - LOAD_M: func=00, data_drive=1, data_o=A.
  - LOAD_Q: func=01, data_drive=1, data_o=B.
  - START: func=10, oe=0, data_drive=0, start=1 for exactly START_HOLD cycles.
  - WAIT_BUSY: start=0. Leave when ready=0.
  - WAIT_DONE: leave when ready=1.
  - READ_LO: func=10, oe=1 for 2 cycles. data_i is sampled into product[n-1:0] on the 2nd cycle, which gives one bus-turnaround cycle.
  - READ_HI: func=11, oe=1 for 2 cycles. data_i is sampled into product[2n-1:n] on the 2nd cycle.
  - DONE: oe=0, func=10, done[g]=1 for one cycle, then return to IDLE.
- Nominal latency from grant to done is 3 + START_HOLD + t_busy + t_mult + 4 cycles.
- Timeout:
  - A counter runs across WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT: product=0, done[g]=1 and error=1 for one cycle, start=0, then IDLE.
- Request dropped mid-operation: the operation still completes and done[g] still pulses. Requesters may ignore it.
- A new req during busy is not granted until IDLE. Earliest regrant is the cycle after DONE.
- data_drive is never high while oe=1; this is guaranteed by state encoding.
- Reset mid-operation: all outputs return to reset values on the next clock, no done pulse is issued, and the captured operation is discarded.
- product holds its value between done pulses.

Decomposition:
- Shared package mult_pkg:
  - typedef state_t enum: IDLE, LOAD_M, LOAD_Q, START, WAIT_BUSY, WAIT_DONE, READ_LO, READ_HI, DONE.
  - Constants FUNC_LOAD_M=2'b00, FUNC_LOAD_Q=2'b01, FUNC_READ_LO=2'b10, FUNC_READ_HI=2'b11.
- Sub-module rr_arbiter2 (2-way round-robin with pointer update on grant). The FSM, counters and capture registers stay in mult_arbiter.

Test Plan:
Bench settings: n=8, START_HOLD=4, TIMEOUT=64, behavioural multiplier model with 9-cycle busy.
- Single request: req[0] with a=13, b=11. Required: func 00 with data_o=0x0D, then 01 with 0x0B, start high exactly 4 cycles, reads, then product=0x008F and done[0] for one cycle. error=0.
- Contention: after reset, req=2'b11 held with a0=255, b0=255, a1=0x7F, b1=0x02. Required: done[0] with 0xFE01 first, then done[1] with 0x00FE, then requester 0 again (alternation).
- Timeout: the model never drops ready. Required: 64 cycles after WAIT_BUSY entry, done[0]=1, error=1, product=0, busy=0 on the next cycle.
- Reset mid-operation: assert reset for 1 cycle during WAIT_DONE. Required: the next cycle shows start=0, func=10, oe=0, data_drive=0, busy=0, product=0, and no done pulse ever appears.
- Dropped request and bus safety: req[0] is dropped during START while req[1] is pending. Required: done[0] still pulses, req[1] is granted the cycle after DONE, and an assertion that data_drive and oe are never both high holds throughout.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter slice.
// Holds the controller state encoding, the multiplier bus function codes,
// and a small helper that turns a requester index into a done vector.
package mult_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD_M    = 4'd1,
    LOAD_Q    = 4'd2,
    START     = 4'd3,
    WAIT_BUSY = 4'd4,
    WAIT_DONE = 4'd5,
    READ_LO   = 4'd6,
    READ_HI   = 4'd7,
    DONE      = 4'd8
  } state_t;

  localparam logic [1:0] FUNC_LOAD_M  = 2'b00;
  localparam logic [1:0] FUNC_LOAD_Q  = 2'b01;
  localparam logic [1:0] FUNC_READ_LO = 2'b10;
  localparam logic [1:0] FUNC_READ_HI = 2'b11;

  // One-hot requester vector for a 1-bit requester index.
  function automatic logic [1:0] idx_to_onehot(input logic idx);
    logic [1:0] vec;
    if (idx) begin
      vec = 2'b10;
    end else begin
      vec = 2'b01;
    end
    return vec;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   req          : request vector
//   accept       : the grant is taken this cycle (pointer updates)
//   valid, idx   : a winner exists / its index
// After reset requester 0 wins a tie; afterwards a tie goes to whichever
// requester was not granted last.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       valid,
  output logic       idx
);

  logic last_q;
  logic last_d;

  // Winner selection: a lone request wins, contention goes to the other side.
  always_comb begin
    valid = 1'b0;
    idx   = 1'b0;
    case (req)
      2'b01:   begin valid = 1'b1; idx = 1'b0;    end
      2'b10:   begin valid = 1'b1; idx = 1'b1;    end
      2'b11:   begin valid = 1'b1; idx = ~last_q; end
      default: begin valid = 1'b0; idx = 1'b0;    end
    endcase
  end

  // Remember who was served, but only when the grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (accept && valid) begin
      last_d = idx;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin controller sharing one shift-add multiplier between two
// requesters. For each grant it loads M and Q over the func/data bus,
// holds start, waits for ready to fall and rise, reads the product back in
// two halves and pulses done for the granted requester.
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   req, a, b           : per-requester level request and operands
//   done, error         : completion pulse per requester, timeout flag
//   product, busy       : last result, controller not idle
//   start, func, oe     : multiplier control
//   data_o, data_drive  : operand toward the pad and its drive enable
//   data_i, ready       : pad readback and multiplier ready
// All outputs are registers computed from the next state, so each output
// lines up with the state it belongs to.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int n          = 8,
  parameter int START_HOLD = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0][n-1:0]   a,
  input  logic [1:0][n-1:0]   b,
  output logic [1:0]          done,
  output logic                error,
  output logic [2*n-1:0]      product,
  output logic                busy,
  output logic                start,
  output logic [1:0]          func,
  output logic                oe,
  output logic [n-1:0]        data_o,
  output logic                data_drive,
  input  logic [n-1:0]        data_i,
  input  logic                ready
);

  localparam int CNT_MAX = (TIMEOUT > START_HOLD) ? TIMEOUT : START_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_HOLD - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_q, gnt_d;
  logic             tmo_q, tmo_d;
  logic [n-1:0]     op_a_q, op_a_d;
  logic [n-1:0]     op_b_q, op_b_d;
  logic [n-1:0]     lo_q, lo_d;
  logic [2*n-1:0]   product_q, product_d;

  logic [1:0]       done_q, done_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic [1:0]       func_q, func_d;
  logic             oe_q, oe_d;
  logic [n-1:0]     data_o_q, data_o_d;
  logic             data_drive_q, data_drive_d;

  logic             arb_valid;
  logic             arb_idx;

  rr_arbiter2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .accept (state_q == IDLE),
    .valid  (arb_valid),
    .idx    (arb_idx)
  );

  // State, counters, captured operands and all output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      gnt_q        <= 1'b0;
      tmo_q        <= 1'b0;
      op_a_q       <= {n{1'b0}};
      op_b_q       <= {n{1'b0}};
      lo_q         <= {n{1'b0}};
      product_q    <= {(2*n){1'b0}};
      done_q       <= 2'b00;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      func_q       <= FUNC_READ_LO;
      oe_q         <= 1'b0;
      data_o_q     <= {n{1'b0}};
      data_drive_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      tmo_q        <= tmo_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      lo_q         <= lo_d;
      product_q    <= product_d;
      done_q       <= done_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      func_q       <= func_d;
      oe_q         <= oe_d;
      data_o_q     <= data_o_d;
      data_drive_q <= data_drive_d;
    end
  end

  // Next-state logic; cnt is reused for the start hold, the shared
  // busy/done timeout window and the two-cycle read turnaround.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    tmo_d     = tmo_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    lo_d      = lo_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = LOAD_M;
          gnt_d   = arb_idx;
          op_a_d  = a[arb_idx];
          op_b_d  = b[arb_idx];
          tmo_d   = 1'b0;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_M: state_d = LOAD_Q;
      LOAD_Q: begin
        state_d = START;
        cnt_d   = CNT_ZERO;
      end
      START: begin
        if (cnt_q == START_LAST) begin
          state_d = WAIT_BUSY;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_BUSY: begin
        // The count carries into WAIT_DONE, so >= catches a window that
        // expires right at the hand-over.
        if (!ready) begin
          state_d = WAIT_DONE;
          cnt_d   = cnt_q + CNT_ONE;
        end else if (cnt_q >= TMO_LAST) begin
          state_d   = DONE;
          tmo_d     = 1'b1;
          product_d = {(2*n){1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_DONE: begin
        if (ready) begin
          state_d = READ_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q >= TMO_LAST) begin
          state_d   = DONE;
          tmo_d     = 1'b1;
          product_d = {(2*n){1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      READ_LO: begin
        // First cycle is bus turnaround; the pad is sampled on the second.
        if (cnt_q == CNT_ZERO) begin
          cnt_d = CNT_ONE;
        end else begin
          lo_d    = data_i;
          state_d = READ_HI;
          cnt_d   = CNT_ZERO;
        end
      end
      READ_HI: begin
        // product changes only together with the done pulse.
        if (cnt_q == CNT_ZERO) begin
          cnt_d = CNT_ONE;
        end else begin
          product_d = {data_i, lo_q};
          state_d   = DONE;
          cnt_d     = CNT_ZERO;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state; data_drive and oe are set in
  // disjoint states so they can never overlap.
  always_comb begin
    done_d       = 2'b00;
    error_d      = 1'b0;
    busy_d       = (state_d != IDLE);
    start_d      = 1'b0;
    func_d       = FUNC_READ_LO;
    oe_d         = 1'b0;
    data_o_d     = {n{1'b0}};
    data_drive_d = 1'b0;
    case (state_d)
      LOAD_M: begin
        func_d       = FUNC_LOAD_M;
        data_drive_d = 1'b1;
        data_o_d     = op_a_d;
      end
      LOAD_Q: begin
        func_d       = FUNC_LOAD_Q;
        data_drive_d = 1'b1;
        data_o_d     = op_b_d;
      end
      START:   start_d = 1'b1;
      READ_LO: oe_d    = 1'b1;
      READ_HI: begin
        func_d = FUNC_READ_HI;
        oe_d   = 1'b1;
      end
      DONE: begin
        done_d  = idx_to_onehot(gnt_d);
        error_d = tmo_d;
      end
      default: begin
      end
    endcase
  end

  assign done       = done_q;
  assign error      = error_q;
  assign product    = product_q;
  assign busy       = busy_q;
  assign start      = start_q;
  assign func       = func_q;
  assign oe         = oe_q;
  assign data_o     = data_o_q;
  assign data_drive = data_drive_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural shift-add
// multiplier (ready low for 9 cycles after start falls) on the pad side.
module tb_mult_arbiter;

  localparam int N   = 8;
  localparam int SH  = 4;
  localparam int TMO = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        req;
  logic [1:0][N-1:0] a;
  logic [1:0][N-1:0] b;
  logic [1:0]        done;
  logic              error;
  logic [2*N-1:0]    product;
  logic              busy;
  logic              start;
  logic [1:0]        func;
  logic              oe;
  logic [N-1:0]      data_o;
  logic              data_drive;
  logic [N-1:0]      data_i;
  logic              ready;

  mult_arbiter #(.n(N), .START_HOLD(SH), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .req(req), .a(a), .b(b),
    .done(done), .error(error), .product(product), .busy(busy),
    .start(start), .func(func), .oe(oe), .data_o(data_o),
    .data_drive(data_drive), .data_i(data_i), .ready(ready)
  );

  always #5 clock = ~clock;

  // ---------------- multiplier model ----------------
  logic [N-1:0]   m_reg = '0;
  logic [N-1:0]   q_reg = '0;
  logic           start_prev = 1'b0;
  int             busy_cnt = 0;
  logic           never_ready = 1'b0;
  logic [2*N-1:0] mult_res;

  assign mult_res = m_reg * q_reg;
  assign ready    = (busy_cnt == 0);
  assign data_i   = oe ? ((func == 2'b11) ? mult_res[2*N-1:N] : mult_res[N-1:0]) : 8'h00;

  always @(posedge clock) begin
    if (data_drive && func == 2'b00) m_reg <= data_o;
    if (data_drive && func == 2'b01) q_reg <= data_o;
    start_prev <= start;
    if (start_prev && !start && !never_ready) busy_cnt <= 9;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]     who;
    logic [2*N-1:0] prod;
    logic           err;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          done_seen = 0;
  int          start_run = 0;
  logic [1:0]  prev_done = 2'b00;
  logic [N-1:0] last_m = '0;
  logic [N-1:0] last_q = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req_v);
    end
  endtask

  // Every-cycle compare against the expected-completion queue and bus rules.
  always @(negedge clock) begin
    if (reset) begin
      start_run = 0;
      prev_done = 2'b00;
    end else begin
      check("bus_conflict", {30'd0, data_drive, oe} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
      check("error_without_done", (error && done == 2'b00) ? 32'd1 : 32'd0, 32'd0);
      if (data_drive && func == 2'b00) last_m = data_o;
      if (data_drive && func == 2'b01) last_q = data_o;
      if (start) begin
        start_run++;
      end else if (start_run != 0) begin
        check("start_hold_len", start_run, SH);
        start_run = 0;
      end
      if (done != 2'b00) begin
        exp_t e;
        done_seen++;
        check("done_single_cycle", {30'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=%b, required no pulse", done);
        end else begin
          e = exp_q.pop_front();
          check("done_who", {30'd0, done}, {30'd0, e.who});
          check("done_product", {16'd0, product}, {16'd0, e.prod});
          check("done_error", {31'd0, error}, {31'd0, e.err});
        end
      end
      prev_done = done;
    end
  end

  // Bounded wait: which 0=start 1=busy 2=ready 3=done!=0, for level lvl.
  task automatic wait_cond(input int which, input logic lvl, input string nm);
    int   k;
    logic hit;
    k = 0;
    hit = 1'b0;
    while (!hit && k < 400) begin
      @(negedge clock);
      case (which)
        0:       hit = (start == lvl);
        1:       hit = (busy == lvl);
        2:       hit = (ready == lvl);
        default: hit = ((done != 2'b00) == lvl);
      endcase
      k++;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_%s: got no event in 400 cycles, required event", nm);
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    req   = 2'b00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    int seen;
    reset = 1'b1;
    req   = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clock);

    // Reset values
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_product", {16'd0, product}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_func", {30'd0, func}, 32'd2);
    check("rst_oe", {31'd0, oe}, 32'd0);
    check("rst_drive", {31'd0, data_drive}, 32'd0);
    check("rst_data_o", {24'd0, data_o}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single request 13 x 11
    a[0] = 8'd13;
    b[0] = 8'd11;
    exp_q.push_back('{2'b01, 16'h008F, 1'b0});
    req = 2'b01;
    wait_cond(3, 1'b1, "single_done");
    req = 2'b00;
    check("single_product", {16'd0, product}, 32'h008F);
    check("single_err", {31'd0, error}, 32'd0);
    check("single_load_m", {24'd0, last_m}, 32'h0D);
    check("single_load_q", {24'd0, last_q}, 32'h0B);
    repeat (3) @(negedge clock);

    // Contention from reset: 0, 1, 0
    reset_pulse();
    a[0] = 8'd255; b[0] = 8'd255;
    a[1] = 8'h7F;  b[1] = 8'h02;
    exp_q.push_back('{2'b01, 16'hFE01, 1'b0});
    exp_q.push_back('{2'b10, 16'h00FE, 1'b0});
    exp_q.push_back('{2'b01, 16'hFE01, 1'b0});
    req = 2'b11;
    wait_cond(3, 1'b1, "cont_done1");
    check("cont1_who", {30'd0, done}, 32'd1);
    check("cont1_prod", {16'd0, product}, 32'hFE01);
    wait_cond(3, 1'b1, "cont_done2");
    check("cont2_who", {30'd0, done}, 32'd2);
    check("cont2_prod", {16'd0, product}, 32'h00FE);
    wait_cond(3, 1'b1, "cont_done3");
    req = 2'b00;
    check("cont3_who", {30'd0, done}, 32'd1);
    repeat (3) @(negedge clock);

    // Timeout: ready never falls
    never_ready = 1'b1;
    a[0] = 8'd3; b[0] = 8'd5;
    exp_q.push_back('{2'b01, 16'h0000, 1'b1});
    req = 2'b01;
    wait_cond(0, 1'b1, "tmo_start_hi");
    wait_cond(0, 1'b0, "tmo_start_lo");
    cnt = 0;
    while (done == 2'b00 && cnt < 200) begin
      @(negedge clock);
      cnt++;
    end
    req = 2'b00;
    check("tmo_latency", cnt, TMO);
    check("tmo_error", {31'd0, error}, 32'd1);
    check("tmo_product", {16'd0, product}, 32'd0);
    @(negedge clock);
    check("tmo_busy_after", {31'd0, busy}, 32'd0);
    never_ready = 1'b0;
    repeat (3) @(negedge clock);

    // Reset during WAIT_DONE
    a[1] = 8'd9; b[1] = 8'd7;
    req = 2'b10;
    wait_cond(2, 1'b0, "rst_ready_low");
    repeat (2) @(negedge clock);
    seen  = done_seen;
    reset = 1'b1;
    req   = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_start", {31'd0, start}, 32'd0);
    check("mid_rst_func", {30'd0, func}, 32'd2);
    check("mid_rst_oe", {31'd0, oe}, 32'd0);
    check("mid_rst_drive", {31'd0, data_drive}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_product", {16'd0, product}, 32'd0);
    repeat (40) @(negedge clock);
    check("mid_rst_no_done", done_seen, seen);

    // Dropped request with requester 1 pending
    a[0] = 8'h21; b[0] = 8'h03;
    a[1] = 8'h10; b[1] = 8'h10;
    exp_q.push_back('{2'b01, 16'h0063, 1'b0});
    exp_q.push_back('{2'b10, 16'h0100, 1'b0});
    req = 2'b01;
    wait_cond(1, 1'b1, "drop_busy");
    req = 2'b11;
    wait_cond(0, 1'b1, "drop_start");
    req = 2'b10;
    wait_cond(3, 1'b1, "drop_done0");
    check("drop_done0_who", {30'd0, done}, 32'd1);
    check("drop_done0_prod", {16'd0, product}, 32'h0063);
    @(negedge clock);
    check("drop_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    check("regrant_func", {30'd0, func}, 32'd0);
    check("regrant_data", {24'd0, data_o}, 32'h10);
    wait_cond(3, 1'b1, "drop_done1");
    req = 2'b00;
    check("drop_done1_who", {30'd0, done}, 32'd2);
    check("drop_done1_prod", {16'd0, product}, 32'h0100);
    repeat (5) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
